// File: rtl/ucsbece152a_count_ctrl_if.sv
// Button/switch inputs and counter-control outputs of the count control stage.
interface ucsbece152a_count_ctrl_if;
   logic btn_step_i;
   logic btn_dir_i;
   logic auto_i;
   logic enable_o;
   logic dir_o;
   logic running_o;

   // Drives the raw buttons/switch and observes the counter controls
   modport master (
      output btn_step_i, btn_dir_i, auto_i,
      input  enable_o, dir_o, running_o
   );

   // The control stage itself
   modport slave (
      input  btn_step_i, btn_dir_i, auto_i,
      output enable_o, dir_o, running_o
   );
endinterface

// File: rtl/ucsbece152a_count_ctrl.sv
// Count control stage: synchronises and debounces the step/direction buttons,
// turns step presses into single-cycle enables, toggles direction on dir
// presses and runs a prescaled auto-count mode with run/pause control.
module ucsbece152a_count_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TICK_DIV        = 50000000
) (
   input logic               clk,
   input logic               rst,
   ucsbece152a_count_ctrl_if.slave io
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned PS_W = $clog2(TICK_DIV);

   typedef enum logic [1:0] {MANUAL, RUN, PAUSED} state_t;

   // bit 0: step button, bit 1: dir button, bit 2: auto switch
   logic [2:0] raw;
   logic [2:0] sync1_q;
   logic [2:0] sync2_q;
   logic       auto_s;
   logic [1:0] press;

   logic step_press;
   logic dir_press;

   state_t          state_q, state_d;
   logic [PS_W-1:0] pre_q, pre_d;
   logic            pre_wrap;
   logic            enable_q, enable_d;
   logic            dir_q, dir_d;
   logic            run_q, run_d;

   assign raw    = {io.auto_i, io.btn_dir_i, io.btn_step_i};
   assign auto_s = sync2_q[2];

   // Two-flop synchronisers for every raw input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_db
      logic [DB_W-1:0] cnt_q;
      logic            db_q;
      logic            db_dly_q;

      // Accept a new level only after DEBOUNCE_CYCLES stable samples; register for edge detect
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
         end else begin
            db_dly_q <= db_q;
            if (sync2_q[g] == db_q) begin
               cnt_q <= '0;
            end else if (32'(cnt_q) == DEBOUNCE_CYCLES - 1) begin
               db_q  <= sync2_q[g];
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + DB_W'(1);
            end
         end
      end

      assign press[g] = db_q & ~db_dly_q;
   end

   assign step_press = press[0];
   assign dir_press  = press[1];
   assign pre_wrap   = (32'(pre_q) == TICK_DIV - 1);

   // Mode FSM and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= MANUAL;
         pre_q    <= '0;
         enable_q <= 1'b0;
         dir_q    <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         enable_q <= enable_d;
         dir_q    <= dir_d;
         run_q    <= run_d;
      end
   end

   // Next state, prescaler and output decode
   always_comb begin
      state_d  = state_q;
      pre_d    = pre_q;
      enable_d = 1'b0;
      dir_d    = dir_q ^ dir_press;
      case (state_q)
         MANUAL: begin
            pre_d    = '0;
            enable_d = step_press;
            if (auto_s) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!auto_s) begin
               state_d = MANUAL;
               pre_d   = '0;
            end else begin
               // The prescaler keeps counting on the pausing edge; a press on
               // the wrap edge wraps the count but swallows that tick.
               if (pre_wrap) begin
                  pre_d    = '0;
                  enable_d = ~step_press;
               end else begin
                  pre_d = pre_q + PS_W'(1);
               end
               if (step_press) begin
                  state_d = PAUSED;
               end
            end
         end
         PAUSED: begin
            if (!auto_s) begin
               state_d = MANUAL;
               pre_d   = '0;
            end else if (step_press) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = MANUAL;
            pre_d   = '0;
         end
      endcase
      run_d = (state_d == RUN);
   end

   assign io.enable_o  = enable_q;
   assign io.dir_o     = dir_q;
   assign io.running_o = run_q;

endmodule

// File: tb/tb_ucsbece152a_count_ctrl.sv
// Directed bench for the count control stage (DEBOUNCE_CYCLES=4, TICK_DIV=8).
// Observed value is {enable_o, dir_o, running_o}; edge k counts rising edges
// after the inputs were changed, outputs are sampled 1 time unit after edge k.
module tb_ucsbece152a_count_ctrl;

   logic clk;
   logic rst;
   int   n_total;
   int   n_pass;

   ucsbece152a_count_ctrl_if ctrl_if ();

   ucsbece152a_count_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .TICK_DIV       (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .io (ctrl_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2:0] obs();
      return {ctrl_if.enable_o, ctrl_if.dir_o, ctrl_if.running_o};
   endfunction

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got {en,dir,run}=%b expected %b at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst = 1'b1;
      ctrl_if.btn_step_i = 1'b0;
      ctrl_if.btn_dir_i  = 1'b0;
      ctrl_if.auto_i     = 1'b0;

      // 1: reset state, then idle outputs after release
      #3;
      chk("reset_async", obs(), 3'b000);
      tick();
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("idle_after_reset", obs(), 3'b000);
      end

      // 2: manual step, held 12 cycles -> one pulse after edge 7
      for (int k = 1; k <= 12; k++) begin
         ctrl_if.btn_step_i = 1'b1;
         tick();
         chk("manual_step", obs(), {(k == 7), 1'b0, 1'b0});
      end
      ctrl_if.btn_step_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("step_release", obs(), 3'b000);
      end

      // 3: three-cycle glitches rejected
      for (int r = 0; r < 3; r++) begin
         for (int k = 1; k <= 8; k++) begin
            ctrl_if.btn_step_i = (k <= 3);
            tick();
            chk("glitch_reject", obs(), 3'b000);
         end
      end
      // four-cycle pulse is just long enough to be accepted
      for (int k = 1; k <= 16; k++) begin
         ctrl_if.btn_step_i = (k <= 4);
         tick();
         chk("min_pulse_accept", obs(), {(k == 7), 1'b0, 1'b0});
      end

      // 4: direction toggles
      for (int k = 1; k <= 20; k++) begin
         ctrl_if.btn_dir_i = (k <= 10);
         tick();
         chk("dir_toggle_up", obs(), {1'b0, (k >= 7), 1'b0});
      end
      for (int k = 1; k <= 20; k++) begin
         ctrl_if.btn_dir_i = (k <= 10);
         tick();
         chk("dir_toggle_back", obs(), {1'b0, (k < 7), 1'b0});
      end

      // 5: auto run, RUN entered at edge 3, ticks at 11, 19, 27, 35
      ctrl_if.auto_i = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         chk("auto_run", obs(), {(k >= 11 && ((k - 11) % 8) == 0), 1'b0, (k >= 3)});
      end
      // prescaler is 5 here: tick at edge 3, pause at edge 7 with count 4
      for (int k = 1; k <= 22; k++) begin
         ctrl_if.btn_step_i = (k <= 12);
         tick();
         chk("auto_pause", obs(), {(k == 3), 1'b0, (k < 7)});
      end
      // resume from held count 4: RUN at edge 7, tick at edge 11
      for (int k = 1; k <= 12; k++) begin
         ctrl_if.btn_step_i = 1'b1;
         tick();
         chk("auto_resume", obs(), {(k == 11), 1'b0, (k >= 7)});
      end
      ctrl_if.btn_step_i = 1'b0;
      ctrl_if.auto_i     = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("auto_exit", obs(), {1'b0, 1'b0, (k < 3)});
      end

      // 6a: step press lands on the prescaler wrap at edge 11
      ctrl_if.auto_i = 1'b1;
      for (int m = 1; m <= 16; m++) begin
         ctrl_if.btn_step_i = (m >= 5);
         tick();
         chk("collide_step_wrap", obs(), {1'b0, 1'b0, (m >= 3 && m < 11)});
      end
      ctrl_if.btn_step_i = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("paused_after_collide", obs(), 3'b000);
      end

      // 6b: resume at edge 7 from count 0, tick and dir toggle together at edge 15
      for (int r = 1; r <= 20; r++) begin
         ctrl_if.btn_step_i = (r <= 12);
         ctrl_if.btn_dir_i  = (r >= 9);
         tick();
         chk("collide_dir_tick", obs(), {(r == 15), (r >= 15), (r >= 7)});
      end

      // reset mid-operation with dir button and auto still held
      #3;
      rst = 1'b1;
      #1;
      chk("reset_mid_op", obs(), 3'b000);
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("after_reset_held", obs(), {(k == 11), (k >= 7), (k >= 3)});
      end

      ctrl_if.btn_dir_i = 1'b0;
      ctrl_if.auto_i    = 1'b0;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ucsbece152a_count_ctrl.md
Name: ucsbece152a_count_ctrl

Overview:
Control stage directly upstream of the up/down counter. It converts raw push-button and switch inputs into the counter's enable and direction inputs. Buttons are synchronised and debounced, step presses become single-cycle enable pulses, and direction presses toggle the direction level. An auto-run mode with run/pause control generates enable pulses from a prescaler.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronised samples needed to accept a button level change; minimum 2.
TICK_DIV, 50000000, clock cycles per auto-run enable pulse; minimum 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
btn_step_i  input  1  raw step/pause button, asynchronous, active-high
btn_dir_i  input  1  raw direction-toggle button, asynchronous, active-high
auto_i  input  1  raw mode switch (0 manual, 1 auto-run), asynchronous
enable_o  output  1  registered one-cycle count-enable pulse, drives counter enable_i
dir_o  output  1  registered direction level (0 up, 1 down), drives counter dir_i
running_o  output  1  registered, high while FSM is in RUN

Behaviour:
- Reset, asynchronous and active-high, has these effects:
  - all synchroniser, debounce, prescaler and edge registers clear to 0
  - FSM goes to MANUAL
  - enable_o=0, dir_o=0, running_o=0
- Synchronisers:
  - Each raw input passes through a 2-flop synchroniser.
  - Synchronised auto_i (auto_s) is not debounced.
- Debouncer, one per button, with synchronised level s, accepted level db, counter cnt of width $clog2(DEBOUNCE_CYCLES):
  - If s==db, cnt is cleared to 0.
  - Otherwise cnt increments.
  - When s!=db and cnt==DEBOUNCE_CYCLES-1, db<=s and cnt<=0.
- Edge detect:
  - db_d<=db every cycle.
  - The press event is db & ~db_d.
  - Release produces no event.
- Latency: with edge 1 as the first edge sampling the raw input high (held stable), db rises at edge 2+DEBOUNCE_CYCLES and the press event is acted on at edge 3+DEBOUNCE_CYCLES.
- A raw pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- Direction: a dir press event toggles dir_o in every FSM state.
- FSM states: MANUAL, RUN, PAUSED.
  - MANUAL: a step press drives enable_o=1 for exactly one cycle. The prescaler is held at 0. If auto_s=1, go to RUN with the prescaler cleared.
  - RUN: the prescaler counts 0..TICK_DIV-1. On wrap (prescaler==TICK_DIV-1), prescaler<=0 and enable_o=1 for one cycle. A step press goes to PAUSED.
  - PAUSED: the prescaler holds its value and no enable pulses occur. A step press goes to RUN and counting resumes from the held value.
  - From RUN or PAUSED, auto_s=0 goes to MANUAL and clears the prescaler. This takes priority over a step press in the same cycle.
- Simultaneous events:
  - A step press coinciding with a prescaler wrap in RUN pauses and suppresses that tick. The prescaler still wraps to 0.
  - A dir press coinciding with an enable pulse updates dir_o on the same edge, so the counter sees the new direction with that pulse.
- enable_o is never high for two consecutive cycles. Guarantee: TICK_DIV>=2, and step pulses are separated by at least a debounce interval.
- running_o=1 iff the state is RUN. It updates on the same edge as the state register.
- Reset mid-operation returns the block to the reset state immediately.
  - A button still held after reset release is treated as a new press. It is accepted 3+DEBOUNCE_CYCLES edges after release.
  - If auto_i is still high, the FSM re-enters RUN once auto_s goes high.
- Counter widths: $clog2 of each parameter. Comparisons against the parameter-1 values are at full width, with no truncation.

Test Plan (DEBOUNCE_CYCLES=4, TICK_DIV=8):
1. Assert rst mid-cycle with buttons idle -> enable_o, dir_o and running_o are 0 immediately; outputs stay 0 for 20 cycles after release.
2. Manual step: btn_step_i held high for 12 cycles -> exactly one enable_o pulse, high only in the cycle after edge 7; dir_o stays 0; no pulse on release.
3. Glitch rejection: btn_step_i high for 3 cycles then low, repeated 3 times -> enable_o never asserts; db stays 0.
4. Direction: two separated btn_dir_i presses of 10 cycles each -> dir_o goes 0->1 at edge 7 of the first press and 1->0 at edge 7 of the second; enable_o stays 0.
5. Auto run/pause: set auto_i=1 and run 40 cycles -> running_o=1, and enable_o pulses every 8 cycles, the first 8 cycles after entering RUN.
   - A step press then stops all pulses and drives running_o=0.
   - A second press resumes, with the first pulse after the remaining prescaler count.
   - Clearing auto_i returns to MANUAL within 3 cycles.
6. Collision: in RUN, time a step press to hit the prescaler wrap -> no enable pulse; state is PAUSED.
   - Separately, time a dir press on a tick -> dir_o toggles on the same edge enable_o rises.
